// File: rtl/pair_link_pkg.sv
// rtl/pair_link_pkg.sv - shared encodings and defaults for the serial pair-detection link
package pair_link_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_GAP   = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_GAP  = 2'b10
    } tx_state_e;

    typedef enum logic [2:0] {
        DET_IDLE = 3'b000,
        DET_S0   = 3'b001,
        DET_S1   = 3'b010,
        DET_S01  = 3'b011,
        DET_S10  = 3'b100,
        DET_S00  = 3'b101,
        DET_S11  = 3'b110
    } det_state_e;

endpackage

// File: rtl/pair_stream_tx_if.sv
// rtl/pair_stream_tx_if.sv - word load handshake plus serial/detector-side signals
interface pair_stream_tx_if
    import pair_link_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W
) ();
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic             ser_out;
    logic             ser_valid;
    logic             det_rst;
    logic             exp_pair;
    logic             done;
    logic [LEN_W-1:0] pair_cnt;

    modport master (
        output load_valid, load_data, load_len,
        input  load_ready, ser_out, ser_valid, det_rst, exp_pair, done, pair_cnt
    );

    modport slave (
        input  load_valid, load_data, load_len,
        output load_ready, ser_out, ser_valid, det_rst, exp_pair, done, pair_cnt
    );
endinterface

// File: rtl/pair_shift_reg.sv
// rtl/pair_shift_reg.sv - left-aligned word shifter with MSB tap, previous-bit history and bit counter
module pair_shift_reg #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] load_data,
    input  logic [LEN_W-1:0] load_len,
    output logic             msb,
    output logic             prev_bit,
    output logic             prev_valid,
    output logic             last
);
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             prev_bit_q, prev_bit_d;
    logic             prev_valid_q, prev_valid_d;

    // Zero fill on both load and shift keeps the MSB tap at 0 whenever no word is in flight.
    always_comb begin
        sr_d         = sr_q;
        cnt_d        = cnt_q;
        prev_bit_d   = prev_bit_q;
        prev_valid_d = prev_valid_q;
        if (load) begin
            sr_d         = load_data << (WIDTH - int'(load_len));
            cnt_d        = load_len;
            prev_bit_d   = 1'b0;
            prev_valid_d = 1'b0;
        end else if (shift) begin
            sr_d         = sr_q << 1;
            cnt_d        = cnt_q - LEN_W'(1);
            prev_bit_d   = sr_q[WIDTH-1];
            prev_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q         <= '0;
            cnt_q        <= '0;
            prev_bit_q   <= 1'b0;
            prev_valid_q <= 1'b0;
        end else begin
            sr_q         <= sr_d;
            cnt_q        <= cnt_d;
            prev_bit_q   <= prev_bit_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    assign msb        = sr_q[WIDTH-1];
    assign prev_bit   = prev_bit_q;
    assign prev_valid = prev_valid_q;
    assign last       = (cnt_q == LEN_W'(1));
endmodule

// File: rtl/seq_det.sv
// rtl/seq_det.sv - Moore detector for "00" or "11" on a serial stream, sync active-high reset
module seq_det
    import pair_link_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out
);
    det_state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (reset) state_q <= DET_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DET_IDLE:                   state_d = in ? DET_S1  : DET_S0;
            DET_S0, DET_S10, DET_S00:   state_d = in ? DET_S01 : DET_S00;
            DET_S1, DET_S01, DET_S11:   state_d = in ? DET_S11 : DET_S10;
            default:                    state_d = DET_IDLE;
        endcase
    end

    always_comb begin
        out = (state_q == DET_S00) || (state_q == DET_S11);
    end
endmodule

// File: rtl/pair_stream_tx.sv
// rtl/pair_stream_tx.sv - serialises loaded words MSB-first and predicts the pair detector output
module pair_stream_tx
    import pair_link_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int GAP   = DEF_GAP
) (
    input  logic             clk,
    input  logic             reset,
    pair_stream_tx_if.slave  lnk
);
    if (GAP < 1 || GAP > 15) begin : g_bad_gap
        $error("pair_stream_tx: GAP must be in 1..15");
    end

    tx_state_e        state_q, state_d;
    logic [3:0]       gap_q, gap_d;
    logic             load_ready_q, load_ready_d;
    logic             ser_valid_q, ser_valid_d;
    logic             det_rst_q, det_rst_d;
    logic             exp_pair_q, exp_pair_d;
    logic             done_q, done_d;
    logic [LEN_W-1:0] pair_cnt_q, pair_cnt_d;

    logic             accept, shifting, pair_hit;
    logic [LEN_W-1:0] len_c;
    logic             msb, prev_bit, prev_valid, last;

    assign accept   = lnk.load_valid && load_ready_q;
    assign len_c    = (lnk.load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : lnk.load_len;
    assign shifting = (state_q == ST_SEND);
    // msb is the bit on ser_out this cycle, so a hit lands in exp_pair one cycle later.
    assign pair_hit = shifting && prev_valid && (msb == prev_bit);

    pair_shift_reg #(.WIDTH(WIDTH), .LEN_W(LEN_W)) u_shift (
        .clk        (clk),
        .reset      (reset),
        .load       (accept),
        .shift      (shifting),
        .load_data  (lnk.load_data),
        .load_len   (len_c),
        .msb        (msb),
        .prev_bit   (prev_bit),
        .prev_valid (prev_valid),
        .last       (last)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            gap_q        <= '0;
            load_ready_q <= 1'b1;
            ser_valid_q  <= 1'b0;
            det_rst_q    <= 1'b1;
            exp_pair_q   <= 1'b0;
            done_q       <= 1'b0;
            pair_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            gap_q        <= gap_d;
            load_ready_q <= load_ready_d;
            ser_valid_q  <= ser_valid_d;
            det_rst_q    <= det_rst_d;
            exp_pair_q   <= exp_pair_d;
            done_q       <= done_d;
            pair_cnt_q   <= pair_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (len_c != '0) begin
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = 4'(GAP - 1);
                    end
                end
            end
            ST_SEND: begin
                if (last) begin
                    state_d = ST_GAP;
                    gap_d   = 4'(GAP - 1);
                end
            end
            ST_GAP: begin
                if (gap_q == '0) state_d = ST_IDLE;
                else             gap_d   = gap_q - 4'd1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered, so they are derived from the state being entered.
    always_comb begin
        load_ready_d = (state_d == ST_IDLE);
        ser_valid_d  = (state_d == ST_SEND);
        det_rst_d    = (state_d != ST_SEND);
        done_d       = (state_d == ST_GAP) && (state_q != ST_GAP);
        exp_pair_d   = pair_hit;
        pair_cnt_d   = pair_cnt_q;
        if (accept)
            pair_cnt_d = '0;
        else if (pair_hit && (pair_cnt_q != '1))
            pair_cnt_d = pair_cnt_q + LEN_W'(1);
    end

    assign lnk.load_ready = load_ready_q;
    assign lnk.ser_out    = msb;
    assign lnk.ser_valid  = ser_valid_q;
    assign lnk.det_rst    = det_rst_q;
    assign lnk.exp_pair   = exp_pair_q;
    assign lnk.done       = done_q;
    assign lnk.pair_cnt   = pair_cnt_q;
endmodule
